// File: rtl/bus_pkg.sv
// Shared constants and state type for the round-robin bus arbiter.
// BUS_ARB_PARITY_EN appends an even-parity bit and lengthens the frame by one.
package bus_pkg;
    localparam int N_NODES = 16;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 64;
    localparam int CRC_W   = 4;
    localparam int CNT_W   = 7;
`ifdef BUS_ARB_PARITY_EN
    localparam int PAR_W   = 1;
`else
    localparam int PAR_W   = 0;
`endif
    // start bit + dest + payload + crc (+ parity)
    localparam int FRAME_LEN = 1 + ID_W + DATA_W + CRC_W + PAR_W;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping 15 -> 0.
module rr_picker
    import bus_pkg::*;
(
    input  logic [N_NODES-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner_id,
    output logic               any_req
);
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        winner_id = '0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int i = N_NODES - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) winner_id = idx;
        end
        any_req = |req;
    end
endmodule

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin arbiter plus MSB-first frame serializer for the shared one-bit bus.
// Optional BUS_ARB_PARITY_EN: append an even-parity bit over dest, data and crc.
module bus_round_robin_arbiter #(
    parameter int N_NODES = bus_pkg::N_NODES,
    parameter int DATA_W  = bus_pkg::DATA_W
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_NODES-1:0]                req,
    input  logic [N_NODES*bus_pkg::ID_W-1:0]  dest_flat,
    input  logic [N_NODES*DATA_W-1:0]         data_flat,
    input  logic [N_NODES*bus_pkg::CRC_W-1:0] crc_flat,
    output logic [N_NODES-1:0]                grant,
    output logic [bus_pkg::ID_W-1:0]          grant_id,
    output logic                              busy,
    output logic                              bus_out,
    output logic                              frame_done
);
    import bus_pkg::*;

    localparam int FLEN = 1 + ID_W + DATA_W + CRC_W + PAR_W;

    state_e               state_q, state_d;
    logic [FLEN-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [N_NODES-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 bout_q, bout_d;
    logic                 done_q, done_d;

    logic [ID_W-1:0]      winner;
    logic                 any_req;
    logic [ID_W-1:0]      w_dest;
    logic [DATA_W-1:0]    w_data;
    logic [CRC_W-1:0]     w_crc;
    logic [FLEN-1:0]      frame;

    rr_picker u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .winner_id (winner),
        .any_req   (any_req)
    );

    assign w_dest = dest_flat[int'(winner)*ID_W +: ID_W];
    assign w_data = data_flat[int'(winner)*DATA_W +: DATA_W];
    assign w_crc  = crc_flat[int'(winner)*CRC_W +: CRC_W];

`ifdef BUS_ARB_PARITY_EN
    assign frame = {1'b1, w_dest, w_data, w_crc, ^{w_dest, w_data, w_crc}};
`else
    assign frame = {1'b1, w_dest, w_data, w_crc};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    // Start bit goes out right away; shreg keeps the remaining FLEN-1 bits.
                    bout_d          = frame[FLEN-1];
                    shreg_d         = frame << 1;
                    cnt_d           = CNT_W'(FLEN - 1);
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    id_d            = winner;
                    busy_d          = 1'b1;
                    state_d         = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    bout_d  = shreg_q[FLEN-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    bout_d  = 1'b0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = id_q + ID_W'(1);
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant      = grant_q;
    assign grant_id   = id_q;
    assign busy       = busy_q;
    assign bus_out    = bout_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor reassembles and checks them.
module tb_bus_round_robin_arbiter;
    import bus_pkg::*;

    localparam int FMAX = 74;
    localparam int FLEN = FRAME_LEN;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   req   = '0;
    logic [63:0]   dest_flat;
    logic [1023:0] data_flat;
    logic [63:0]   crc_flat;
    logic [15:0]   grant;
    logic [3:0]    grant_id;
    logic          busy, bus_out, frame_done;

    logic [3:0]    st_dest [16];
    logic [63:0]   st_data [16];
    logic [3:0]    st_crc  [16];

    always_comb begin
        dest_flat = '0;
        data_flat = '0;
        crc_flat  = '0;
        for (int i = 0; i < 16; i++) begin
            dest_flat[4*i +: 4]   = st_dest[i];
            data_flat[64*i +: 64] = st_data[i];
            crc_flat[4*i +: 4]    = st_crc[i];
        end
    end

    bus_round_robin_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .dest_flat  (dest_flat),
        .data_flat  (data_flat),
        .crc_flat   (crc_flat),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .bus_out    (bus_out),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int              id;
        logic [FMAX-1:0] frame;
        int              period;
    } exp_t;
    exp_t exp_q[$];
    int   frames_seen = 0;

    task automatic check(input string name, input logic [FMAX-1:0] act, input logic [FMAX-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [FMAX-1:0] mk_frame(input logic [3:0] d, input logic [63:0] x, input logic [3:0] c);
`ifdef BUS_ARB_PARITY_EN
        return {1'b1, d, x, c, ^{d, x, c}};
`else
        return {1'b0, 1'b1, d, x, c};
`endif
    endfunction

    function automatic exp_t mk_exp(input int id, input int period);
        exp_t e;
        e.id     = id;
        e.frame  = mk_frame(st_dest[id], st_data[id], st_crc[id]);
        e.period = period;
        return e;
    endfunction

    // Monitor
    logic            in_frame = 1'b0;
    logic            fd_prev  = 1'b0;
    logic            held_ok;
    logic [15:0]     cur_grant;
    logic [3:0]      cur_id;
    logic [FMAX-1:0] col;
    int              nbits, start_cyc, last_start;

    always @(negedge clock) begin
        if (reset) begin
            in_frame = 1'b0;
            fd_prev  = 1'b0;
        end else begin
            if (fd_prev) check("frame_done_one_cycle", FMAX'(frame_done), '0);
            fd_prev = frame_done;
            if (busy && !in_frame) begin
                in_frame   = 1'b1;
                last_start = start_cyc;
                start_cyc  = cyc;
                cur_grant  = grant;
                cur_id     = grant_id;
                col        = '0;
                nbits      = 0;
                held_ok    = 1'b1;
            end
            if (in_frame && busy) begin
                col = {col[FMAX-2:0], bus_out};
                nbits++;
                if (grant !== cur_grant || grant_id !== cur_id) held_ok = 1'b0;
            end
            if (frame_done) begin
                frames_seen++;
                if (!in_frame) begin
                    check("frame_done_without_frame", FMAX'(frame_done), '0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame_id", FMAX'(cur_id), FMAX'(16));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("grant_id",     FMAX'(cur_id),    FMAX'(e.id));
                    check("grant_onehot", FMAX'(cur_grant), FMAX'(16'(1) << e.id));
                    check("grant_held",   FMAX'(held_ok),   FMAX'(1));
                    check("frame_bits",   col,              e.frame);
                    check("frame_len",    FMAX'(nbits),     FMAX'(FLEN));
                    check("gap_outputs",  FMAX'({grant, busy, bus_out}), '0);
                    if (e.period != 0)
                        check("grant_period", FMAX'(start_cyc - last_start), FMAX'(e.period));
                end
                in_frame = 1'b0;
            end
        end
    end

    // Stimulus
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_seen < n && k < budget) begin
            step();
            k++;
        end
        check("frames_seen", FMAX'(frames_seen), FMAX'(n));
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!busy && k < budget) begin
            step();
            k++;
        end
        check("busy_seen", FMAX'(busy), FMAX'(1));
    endtask

    initial begin
        exp_t e;
        int   base;
        for (int i = 0; i < 16; i++) begin
            st_dest[i] = 4'(i);
            st_data[i] = {16{4'(i)}} ^ 64'hA5A5_0F0F_3C3C_9696;
            st_crc[i]  = ~4'(i);
        end

        repeat (3) step();
        check("reset_outputs", FMAX'({grant, grant_id, busy, bus_out, frame_done}), '0);
        reset = 1'b0;
        repeat (10) step();
        check("idle_outputs", FMAX'({grant, grant_id, busy, bus_out, frame_done}), '0);

        // Single station, hand-written frame.
        st_dest[0] = 4'h1; st_data[0] = 64'h1; st_crc[0] = 4'h1;
        e.id = 0; e.period = 0;
`ifdef BUS_ARB_PARITY_EN
        e.frame = {1'b1, 4'h1, 64'h1, 4'h1, 1'b1};
`else
        e.frame = {1'b0, 1'b1, 4'h1, 64'h1, 4'h1};
`endif
        exp_q.push_back(e);
        base = frames_seen;
        req = 16'h0001;
        wait_busy(5);
        req = 16'h0000;
        wait_frames(base + 1, 100);
        repeat (5) step();
        check("no_regrant", FMAX'(busy), '0);

        // All-ones frame (parity bit 0 when enabled); ptr is 1 so station 3 wins.
        st_dest[3] = 4'hF; st_data[3] = '1; st_crc[3] = 4'hF;
        e.id = 3; e.period = 0;
`ifdef BUS_ARB_PARITY_EN
        e.frame = {1'b1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 1'b0};
`else
        e.frame = {1'b0, 1'b1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF};
`endif
        exp_q.push_back(e);
        base = frames_seen;
        req = 16'h0008;
        wait_busy(5);
        req = 16'h0000;
        wait_frames(base + 1, 100);

        // Saturation: 0..15 then 0, one frame every FLEN+2 cycles.
        do_reset();
        for (int i = 0; i < 17; i++) exp_q.push_back(mk_exp(i % 16, (i == 0) ? 0 : FLEN + 2));
        base = frames_seen;
        req = 16'hFFFF;
        wait_frames(base + 17, 17 * 80);
        req = 16'h0000;

        // Fairness between two stations.
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_exp(i % 2, (i == 0) ? 0 : FLEN + 2));
        base = frames_seen;
        req = 16'h0003;
        wait_frames(base + 4, 4 * 80);
        req = 16'h0000;

        // Mid-frame changes are ignored (ptr is 2, station 0 still only requester).
        st_data[0] = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back(mk_exp(0, 0));
        base = frames_seen;
        req = 16'h0001;
        wait_busy(5);
        repeat (10) step();
        st_data[0] = '1;
        req = 16'h0000;
        wait_frames(base + 1, 100);
        repeat (100) step();
        check("no_second_grant", FMAX'(frames_seen), FMAX'(base + 1));

        // Reset mid-frame, then ptr must be back at 0: 0x0101 grants 0 before 8.
        req = 16'h0001;
        wait_busy(5);
        req = 16'h0000;
        repeat (20) step();
        reset = 1'b1;
        #1;
        check("async_reset_outputs", FMAX'({grant, grant_id, busy, bus_out, frame_done}), '0);
        repeat (2) step();
        reset = 1'b0;
        step();
        exp_q.push_back(mk_exp(0, 0));
        exp_q.push_back(mk_exp(8, FLEN + 2));
        base = frames_seen;
        req = 16'h0101;
        wait_frames(base + 2, 200);
        req = 16'h0000;

        repeat (5) step();
        check("queue_empty", FMAX'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
